ifu_mem_responder: RTL

//  Memory-side responder for IFU line requests: the far end of the mem_reqTag / mem_rspTag protocol.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_tag_fifo.sv | 67 ++++++
 rtl/ifu_mem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared IFU widths and types used by the instruction-memory responder.
//   ADDR_WIDTH   byte address width
//   OFFSET_WIDTH log2 of line size in bytes
//   TAG_WIDTH    line tag width (address minus line offset)
//   LINE_WIDTH   line width in bits
//   VALID        active level of valid strobes
//   rsp_state_t  responder FSM states
// ---------------------------------------------------------------------------
package ifu_pkg;
    localparam int   ADDR_WIDTH   = 32;
    localparam int   OFFSET_WIDTH = 4;
    localparam int   TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int   LINE_WIDTH   = 8 * (2 ** OFFSET_WIDTH);
    localparam logic VALID        = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } rsp_state_t;
endpackage

// File: rtl/ifu_tag_fifo.sv
// ---------------------------------------------------------------------------
// ifu_tag_fifo
// In-order queue of pending line tags with a combinational "tag already
// queued" lookup across all valid entries.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_tag     enqueue i_tag (ignored when full)
//   i_pop, o_head     dequeue; o_head is the oldest entry
//   i_match_tag       tag to look up
//   o_match           i_match_tag equals some valid entry
//   o_full, o_empty   occupancy flags
// ---------------------------------------------------------------------------
module ifu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_tag,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    input  logic [W-1:0] i_match_tag,
    output logic         o_match,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [DEPTH-1:0]        r_vld;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [DEPTH-1:0]        w_hit;
    logic                    w_push;
    logic                    w_pop;

    // Entries are always contiguous in the ring, so per-entry valid bits
    // give full/empty directly and double as the match qualifier.
    assign o_full  = &r_vld;
    assign o_empty = ~|r_vld;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign w_hit[i] = r_vld[i] & (r_mem[i] == i_match_tag);
    end
    assign o_match = |w_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_tag;
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
        end
    end
endmodule

// File: rtl/ifu_mem_responder.sv
// ---------------------------------------------------------------------------
// ifu_mem_responder
// Memory-side end of the IFU tag request / line response protocol. Queues
// level-held tag requests (duplicates filtered), reads each line one word
// per cycle from the instruction SRAM, and returns tag + line with a
// single-cycle valid pulse, in acceptance order, one line in flight.
//   Clock, Rst               clock, synchronous active-high reset
//   mem_reqTagValidIn/TagIn  request (level, may be held)
//   mem_rspInsLineValidOut   one-cycle response pulse
//   mem_rspTagOut/InsLineOut response tag and line (word 0 in LSBs), held
//   sram_rdEnOut/rdAddrOut   SRAM read port, data returns one cycle later
//   sram_rdDataIn            SRAM read data
//   busyOut                  FSM active or requests pending
//   reqDropOut               new request refused because the queue is full
// ---------------------------------------------------------------------------
module ifu_mem_responder
    import ifu_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int WORD_W    = 32
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  mem_reqTagValidIn,
    input  logic [TAG_WIDTH-1:0]  mem_reqTagIn,
    output logic                  mem_rspInsLineValidOut,
    output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
    output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
    output logic                  sram_rdEnOut,
    output logic [ADDR_WIDTH-1:0] sram_rdAddrOut,
    input  logic [WORD_W-1:0]     sram_rdDataIn,
    output logic                  busyOut,
    output logic                  reqDropOut
);
    localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_W;
    localparam int WCNT_W         = $clog2(WORDS_PER_LINE);
    localparam int BOFF_W         = OFFSET_WIDTH - WCNT_W;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);

    rsp_state_t                              r_state;
    logic [TAG_WIDTH-1:0]                    r_cur_tag;
    logic [WCNT_W-1:0]                       r_word_cnt;
    logic                                    r_rd_en;
    logic [ADDR_WIDTH-1:0]                   r_rd_addr;
    logic                                    r_cap_vld;
    logic [WCNT_W-1:0]                       r_cap_idx;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   r_line;
    logic                                    r_rsp_vld;
    logic [TAG_WIDTH-1:0]                    r_rsp_tag;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   r_rsp_line;

    logic                                    w_fifo_full;
    logic                                    w_fifo_empty;
    logic                                    w_fifo_match;
    logic [TAG_WIDTH-1:0]                    w_fifo_head;
    logic                                    w_dup;
    logic                                    w_req;
    logic                                    w_push;
    logic                                    w_pop;
    logic [WCNT_W-1:0]                       w_cnt_nxt;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   w_line_done;

    // A request is a duplicate if it is already queued or is the line
    // currently being read; the requester holds valid, so ignoring it is safe.
    assign w_dup  = w_fifo_match | ((r_state != IDLE) && (mem_reqTagIn == r_cur_tag));
    assign w_req  = (mem_reqTagValidIn == VALID) & ~Rst;
    assign w_push = w_req & ~w_dup & ~w_fifo_full;
    assign w_pop  = (r_state == IDLE) & ~w_fifo_empty & ~Rst;

    assign reqDropOut = w_req & ~w_dup & w_fifo_full;
    assign busyOut    = (r_state != IDLE) | ~w_fifo_empty;

    ifu_tag_fifo #(
        .DEPTH (REQ_DEPTH),
        .W     (TAG_WIDTH)
    ) u_tag_fifo (
        .i_clk       (Clock),
        .i_rst       (Rst),
        .i_push      (w_push),
        .i_tag       (mem_reqTagIn),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .i_match_tag (mem_reqTagIn),
        .o_match     (w_fifo_match),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_cnt_nxt = r_word_cnt + WCNT_W'(1);

    // Line with the word arriving this cycle merged in; in WAIT this is the
    // complete line because the last word is still on the SRAM bus.
    always_comb begin
        w_line_done = r_line;
        if (r_cap_vld) w_line_done[r_cap_idx] = sram_rdDataIn;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_cur_tag  <= '0;
            r_word_cnt <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_idx  <= '0;
            r_line     <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_tag  <= '0;
            r_rsp_line <= '0;
        end else begin
            // Read data lags rdEn by one cycle: remember which slot it targets.
            r_cap_vld <= (r_state == READ);
            r_cap_idx <= r_word_cnt;
            if (r_cap_vld) r_line[r_cap_idx] <= sram_rdDataIn;
            r_rsp_vld <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_cur_tag  <= w_fifo_head;
                        r_word_cnt <= '0;
                        r_rd_en    <= 1'b1;
                        r_rd_addr  <= {w_fifo_head, {WCNT_W{1'b0}}, {BOFF_W{1'b0}}};
                        r_state    <= READ;
                    end
                end
                READ: begin
                    r_word_cnt <= w_cnt_nxt;
                    if (r_word_cnt == LAST_WORD) begin
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                        r_state   <= WAIT;
                    end else begin
                        r_rd_addr <= {r_cur_tag, w_cnt_nxt, {BOFF_W{1'b0}}};
                    end
                end
                WAIT: begin
                    r_rsp_vld  <= 1'b1;
                    r_rsp_tag  <= r_cur_tag;
                    r_rsp_line <= w_line_done;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sram_rdEnOut           = r_rd_en;
    assign sram_rdAddrOut         = r_rd_addr;
    assign mem_rspInsLineValidOut = r_rsp_vld;
    assign mem_rspTagOut          = r_rsp_tag;
    assign mem_rspInsLineOut      = r_rsp_line;
endmodule
